// File: rtl/stream_width_upsizer_if.sv
// Handshake bundle for the narrow-to-wide stream packer.
// The slave view is the packer itself; the master view is the surrounding
// logic that feeds narrow beats and accepts wide words.
interface stream_width_upsizer_if #(
  parameter int DW    = 8,
  parameter int RATIO = 4
);
  logic                  valid_i;
  logic                  ready_o;
  logic [DW-1:0]         data_i;
  logic                  last_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DW*RATIO-1:0]   data_o;
  logic [RATIO-1:0]      keep_o;
  logic                  last_o;

  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, keep_o, last_o
  );

  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, keep_o, last_o
  );
endinterface

// File: rtl/stream_width_upsizer.sv
// Packs RATIO narrow beats of DW bits into one wide word. A beat flagged
// last closes the word early; unused upper lanes are zeroed and masked off
// by keep_o. Input ready is a single gate off the output register state so
// the upstream sees full throughput whenever the downstream is draining.
module stream_width_upsizer #(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int CW    = $clog2(RATIO)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  stream_width_upsizer_if.slave bus
);

  // Partial word being gathered and the lane the next beat goes into.
  logic [RATIO-1:0][DW-1:0] acc_q, acc_d;
  logic [CW-1:0]            idx_q, idx_d;

  // Output register; holds its contents stable until the word is taken.
  logic [RATIO-1:0][DW-1:0] data_q, data_d;
  logic [RATIO-1:0]         keep_q, keep_d;
  logic                     last_q, last_d;
  logic                     valid_q, valid_d;

  logic                     ready;
  logic                     in_fire;
  logic                     out_fire;
  logic                     at_top;
  logic                     complete;
  logic [RATIO-1:0][DW-1:0] merged;
  logic [RATIO-1:0]         keep_new;

  // A slot opens whenever the output register is empty or draining this cycle.
  assign ready    = !valid_q || bus.ready_i;
  assign in_fire  = bus.valid_i && ready;
  assign out_fire = valid_q && bus.ready_i;
  assign at_top   = (idx_q == CW'(RATIO - 1));
  assign complete = in_fire && (at_top || bus.last_i);

  // Build the word the completing beat produces: lanes below idx from the
  // accumulator, lane idx from the incoming beat, everything above zeroed.
  always_comb begin
    merged   = '0;
    keep_new = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(idx_q)) begin
        merged[k] = acc_q[k];
      end else if (k == int'(idx_q)) begin
        merged[k] = bus.data_i;
      end else begin
        merged[k] = '0;
      end
      keep_new[k] = (k <= int'(idx_q));
    end
  end

  // Accumulator next state: store mid-word beats, restart after a completion.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (in_fire) begin
      if (complete) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d[idx_q] = bus.data_i;
        idx_d        = idx_q + CW'(1);
      end
    end
  end

  // Output register next state: a completing beat wins over a plain drain,
  // which is what keeps back-to-back words at full rate.
  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (complete) begin
      data_d  = merged;
      keep_d  = keep_new;
      last_d  = bus.last_i;
      valid_d = 1'b1;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  // State registers; clear_i overrides any handshake in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.keep_o  = keep_q;
  assign bus.last_o  = last_q;

endmodule

// File: tb/tb_stream_width_upsizer.sv
// Bench for the stream packer: directed scenarios followed by random
// traffic, all checked against a beat-list reference model.
module tb_stream_width_upsizer;
  localparam int DW    = 8;
  localparam int RATIO = 4;

  typedef struct packed {
    logic [DW*RATIO-1:0] d;
    logic [RATIO-1:0]    k;
    logic                l;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  int total = 0;
  int bad   = 0;

  word_t       exp_q[$];
  logic [7:0]  part[$];

  stream_width_upsizer_if #(.DW(DW), .RATIO(RATIO)) bus();

  stream_width_upsizer #(.DW(DW), .RATIO(RATIO)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clr),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check before posedge, update model at posedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic rdy, input logic c);
    logic  in_f, out_f;
    word_t w;
    @(negedge clk);
    bus.valid_i = v;
    bus.data_i  = d;
    bus.last_i  = l;
    bus.ready_i = rdy;
    clr         = c;
    #1;
    chk("valid_o", 64'(bus.valid_o), 64'(exp_q.size() != 0));
    chk("ready_o", 64'(bus.ready_o), 64'((exp_q.size() == 0) || rdy));
    if (exp_q.size() != 0) begin
      chk("data_o", 64'(bus.data_o), 64'(exp_q[0].d));
      chk("keep_o", 64'(bus.keep_o), 64'(exp_q[0].k));
      chk("last_o", 64'(bus.last_o), 64'(exp_q[0].l));
    end
    in_f  = v && ((exp_q.size() == 0) || rdy) && !c;
    out_f = (exp_q.size() != 0) && rdy && !c;
    @(posedge clk);
    if (c) begin
      exp_q.delete();
      part.delete();
    end else begin
      if (out_f) void'(exp_q.pop_front());
      if (in_f) begin
        part.push_back(d);
        if (part.size() == RATIO || l) begin
          w.d = '0;
          for (int i = 0; i < part.size(); i++) w.d[i*DW +: DW] = part[i];
          w.k = RATIO'((1 << part.size()) - 1);
          w.l = l;
          exp_q.push_back(w);
          part.delete();
        end
      end
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    cycle(1'b1, d, l, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, 64'(bus.valid_o), 64'd0);
    chk({tag, "_keep"},  64'(bus.keep_o),  64'd0);
    chk({tag, "_data"},  64'(bus.data_o),  64'd0);
    exp_q.delete();
    part.delete();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.last_i  = 1'b0;
    bus.ready_i = 1'b0;
    #3;
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_data",  64'(bus.data_o),  64'd0);
    chk("rst_keep",  64'(bus.keep_o),  64'd0);
    chk("rst_last",  64'(bus.last_o),  64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full word, no last.
    beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
    chk("w1_data", 64'(exp_q[0].d), 64'h44332211);
    idle(2);

    // Early close, then next beat starts at lane 0.
    beat(8'hA1, 1'b0); beat(8'hA2, 1'b1);
    beat(8'hB1, 1'b1);
    idle(2);

    // Stall with a full word pending, offer 0x05 for 10 cycles.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h05, 1'b0, 1'b1, 1'b0);
    beat(8'h06, 1'b0); beat(8'h07, 1'b0); beat(8'h08, 1'b0);
    idle(2);

    // Continuous 16-beat stream.
    for (int i = 0; i < 16; i++) beat(8'(i), 1'b0);
    idle(2);

    // Synchronous clear after a partial word.
    beat(8'hC1, 1'b0); beat(8'hC2, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1);
    chk("clr_valid", 64'(bus.valid_o), 64'd0);
    beat(8'hD1, 1'b1);
    idle(2);

    // Async reset with a partial word, then with a pending word.
    beat(8'h77, 1'b0);
    async_reset("arst_part");
    beat(8'hE1, 1'b1);
    idle(2);
    beat(8'h91, 1'b1);
    async_reset("arst_full");
    beat(8'hF1, 1'b0); beat(8'hF2, 1'b1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 49) == 0);
    end

    // Drain anything left, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
